// File: rtl/crm_pkg.sv
// Shared types and defaults for the parametrised CRAM control store.
package crm_pkg;

    // Default geometry: 2K words of 84 bits, loaded as 21-bit slices.
    localparam int CRM_ADDR_W  = 12;
    localparam int CRM_DEPTH   = 2048;
    localparam int CRM_WORD_W  = 84;
    localparam int CRM_CHUNK_W = 21;

    // Burst-load engine states.
    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_DONE    = 2'd3
    } ld_state_t;

    // Number of slices needed to cover one microword.
    function automatic int nchunk(input int word_w, input int chunk_w);
        return (word_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/crm_store_ram.sv
// Single-port synchronous RAM with a registered, enable-gated read.
// When rd_fill is set the read register loads the fill value instead of
// the array, which the top uses for unimplemented addresses.
module crm_store_ram #(
    parameter int DEPTH  = 2048,
    parameter int IDX_W  = 11,
    parameter int DATA_W = 85
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_fill,
    input  logic [DATA_W-1:0] fill,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: updates only when enabled, otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_fill ? fill : mem[addr];
        end
    end

endmodule

// File: rtl/crm_store.sv
// CRAM control store: registered microword read with hold, per-word odd
// parity with a sticky error flag, and a slice-based burst-load engine.
//
// Load handshake: a slice transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_ready is a registered output that is high only
// in COLLECT, and ld_chunk must stay stable while ld_valid & ~ld_ready.
module crm_store
    import crm_pkg::*;
#(
    parameter int ADDR_W  = CRM_ADDR_W,
    parameter int DEPTH   = CRM_DEPTH,
    parameter int WORD_W  = CRM_WORD_W,
    parameter int CHUNK_W = CRM_CHUNK_W,
    parameter int PAR_EN  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  cradr,
    input  logic               cram_hold,
    output logic [WORD_W-1:0]  cram_data,
    output logic               par_err,
    input  logic               par_err_clr,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [ADDR_W-1:0]  ld_nwords,
    input  logic               ld_bad_par,
    input  logic               ld_valid,
    input  logic [CHUNK_W-1:0] ld_chunk,
    output logic               ld_ready,
    output logic               ld_busy,
    output logic               ld_done,
    output logic [1:0]         ld_state
);

    localparam int NCH   = nchunk(WORD_W, CHUNK_W);
    localparam int BUF_W = NCH * CHUNK_W;
    localparam int KW    = $clog2(NCH + 1);
    localparam int RAM_W = WORD_W + PAR_EN;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [KW-1:0]     LAST_K    = KW'(NCH - 1);

    ld_state_t          state;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               bad_q;
    logic [KW-1:0]      k_q;
    logic [BUF_W-1:0]   buf_q;

    logic               accept;
    logic               rd_en;
    logic               rd_oor;
    logic               wr_en;
    logic [IDX_W-1:0]   ram_addr;
    logic [WORD_W-1:0]  wr_word;
    logic [RAM_W-1:0]   ram_wdata;
    logic [RAM_W-1:0]   ram_fill;
    logic [RAM_W-1:0]   ram_rdata;

    assign accept   = (state == LD_COLLECT) && ld_valid && ld_ready;
    assign ld_state = state;

    // The single RAM port serves the write in WRITE and the read otherwise;
    // the read register is frozen during WRITE so the port is never shared.
    assign rd_en    = !cram_hold && (state != LD_WRITE);
    assign rd_oor   = {1'b0, cradr} >= DEPTH_X;
    assign wr_en    = (state == LD_WRITE) && ({1'b0, addr_q} < DEPTH_X);
    assign ram_addr = (state == LD_WRITE) ? addr_q[IDX_W-1:0] : cradr[IDX_W-1:0];

    // Slice 0 occupies the top of the buffer (KL bit 0 = MSB); any bits of
    // the last slice that fall below the word are dropped here.
    assign wr_word  = buf_q[BUF_W-1 -: WORD_W];
    assign cram_data = ram_rdata[WORD_W-1:0];

    // Load engine: latch burst parameters, count slices and words, sequence writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LD_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            k_q      <= '0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (ld_start) begin
                        addr_q   <= ld_addr;
                        cnt_q    <= ld_nwords;
                        bad_q    <= ld_bad_par;
                        k_q      <= '0;
                        state    <= LD_COLLECT;
                        ld_ready <= 1'b1;
                        ld_busy  <= 1'b1;
                    end
                end
                LD_COLLECT: begin
                    if (accept) begin
                        k_q <= k_q + 1'b1;
                        if (k_q == LAST_K) begin
                            state    <= LD_WRITE;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                LD_WRITE: begin
                    if (cnt_q == '0) begin
                        state   <= LD_DONE;
                        ld_done <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q - 1'b1;
                        addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                        k_q      <= '0;
                        state    <= LD_COLLECT;
                        ld_ready <= 1'b1;
                    end
                end
                LD_DONE: begin
                    state   <= LD_IDLE;
                    ld_busy <= 1'b0;
                end
                default: begin
                    state    <= LD_IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Slice assembly buffer: each accepted slice lands in its own field.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (accept && (k_q == KW'(i))) begin
                buf_q[BUF_W-1-i*CHUNK_W -: CHUNK_W] <= ld_chunk;
            end
        end
    end

    generate
        if (PAR_EN != 0) begin : g_par
            logic wr_par;
            logic upd_q;

            // Odd parity over data+parity; a bad-parity burst stores the inverse.
            assign wr_par    = ~(^wr_word) ^ bad_q;
            assign ram_wdata = {wr_par, wr_word};
            // Unimplemented addresses read as zero with a correct (odd) parity bit.
            assign ram_fill  = {1'b1, {WORD_W{1'b0}}};

            // Sticky error: flag an even-weight word one edge after it loads; set beats clear.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    upd_q   <= 1'b0;
                    par_err <= 1'b0;
                end else begin
                    upd_q <= rd_en;
                    if (upd_q && !(^ram_rdata)) begin
                        par_err <= 1'b1;
                    end else if (par_err_clr) begin
                        par_err <= 1'b0;
                    end
                end
            end
        end else begin : g_nopar
            assign ram_wdata = wr_word;
            assign ram_fill  = '0;
            assign par_err   = 1'b0;
        end
    endgenerate

    crm_store_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rd_en   (rd_en),
        .rd_fill (rd_oor),
        .fill    (ram_fill),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_crm_store.sv
// Randomised bench for crm_store against a word-level memory model.
module tb_crm_store;
    import crm_pkg::*;

    localparam int ADDR_W  = CRM_ADDR_W;
    localparam int DEPTH   = CRM_DEPTH;
    localparam int WORD_W  = CRM_WORD_W;
    localparam int CHUNK_W = CRM_CHUNK_W;
    localparam int NCH     = nchunk(WORD_W, CHUNK_W);
    localparam int BUF_W   = NCH * CHUNK_W;
    localparam int ASPACE  = 1 << ADDR_W;

    logic               clk;
    logic               reset_n;
    logic [ADDR_W-1:0]  cradr;
    logic               cram_hold;
    logic [WORD_W-1:0]  cram_data;
    logic               par_err;
    logic               par_err_clr;
    logic               ld_start;
    logic [ADDR_W-1:0]  ld_addr;
    logic [ADDR_W-1:0]  ld_nwords;
    logic               ld_bad_par;
    logic               ld_valid;
    logic [CHUNK_W-1:0] ld_chunk;
    logic               ld_ready;
    logic               ld_busy;
    logic               ld_done;
    logic [1:0]         ld_state;

    // Scoreboard and reference memory
    logic [WORD_W-1:0]  exp_q[$];
    logic [WORD_W-1:0]  model_mem[int];
    bit                 model_bad[int];
    int                 good_q[$];
    logic [CHUNK_W-1:0] fixed_slices[$];
    int                 n_cmp;
    int                 n_err;
    bit                 aborted;

    crm_store dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cradr       (cradr),
        .cram_hold   (cram_hold),
        .cram_data   (cram_data),
        .par_err     (par_err),
        .par_err_clr (par_err_clr),
        .ld_start    (ld_start),
        .ld_addr     (ld_addr),
        .ld_nwords   (ld_nwords),
        .ld_bad_par  (ld_bad_par),
        .ld_valid    (ld_valid),
        .ld_chunk    (ld_chunk),
        .ld_ready    (ld_ready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_state    (ld_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference read: unimplemented addresses return zero.
    function automatic logic [WORD_W-1:0] exp_read(input int a);
        if (a >= DEPTH) return '0;
        if (model_mem.exists(a)) return model_mem[a];
        return 'x;
    endfunction

    // Burst address sequence: wrap at the last implemented word, else modulo the address space.
    function automatic int next_addr(input int a);
        if (a == DEPTH - 1) return 0;
        return (a + 1) % ASPACE;
    endfunction

    // A read target that cannot raise a parity error.
    function automatic int pick_addr();
        int a;
        if (good_q.size() == 0 || $urandom_range(0, 3) == 0)
            return int'($urandom_range(DEPTH, ASPACE - 1));
        a = good_q[$urandom_range(0, good_q.size() - 1)];
        if (model_bad.exists(a) && model_bad[a]) return DEPTH;
        return a;
    endfunction

    // One clock with random read traffic; checks hold / write suppression / read data.
    task automatic cycle(input bit allow_hold, input bit wr_cycle);
        logic [WORD_W-1:0] prev;
        bit hold;
        int a;
        prev = cram_data;
        hold = allow_hold ? ($urandom_range(0, 2) == 0) : 1'b0;
        a = pick_addr();
        cram_hold = hold;
        cradr = ADDR_W'(a);
        if (!hold && !wr_cycle) exp_q.push_back(exp_read(a));
        @(posedge clk);
        #1;
        if (hold) check_val("hold_keeps", 128'(cram_data), 128'(prev));
        else if (wr_cycle) check_val("write_keeps", 128'(cram_data), 128'(prev));
        else check_val("stall_read", 128'(cram_data), 128'(exp_q.pop_front()));
    endtask

    task automatic read_at(input int a, input string tag);
        cram_hold = 1'b0;
        cradr = ADDR_W'(a);
        exp_q.push_back(exp_read(a));
        @(posedge clk);
        #1;
        check_val(tag, 128'(cram_data), 128'(exp_q.pop_front()));
    endtask

    // Drive a complete burst, updating the model as each word is written.
    task automatic load_burst(input int a, input int n, input bit bad, input bit stress);
        logic [BUF_W-1:0]   acc;
        logic [CHUNK_W-1:0] c;
        int wa;
        int guard;
        bit acc_now;
        ld_addr = ADDR_W'(a);
        ld_nwords = ADDR_W'(n);
        ld_bad_par = bad;
        ld_start = 1'b1;
        ld_valid = 1'b0;
        cycle(1'b0, 1'b0);
        ld_start = 1'b0;
        check_val("busy_on_start", 128'(ld_busy), 128'(1));
        check_val("ready_on_start", 128'(ld_ready), 128'(1));
        wa = a;
        for (int w = 0; w <= n; w++) begin
            acc = '0;
            for (int k = 0; k < NCH; k++) begin
                c = (fixed_slices.size() > 0) ? fixed_slices.pop_front() : CHUNK_W'($urandom());
                acc = {acc[BUF_W-CHUNK_W-1:0], c};
                guard = 0;
                do begin
                    ld_valid = stress ? ($urandom_range(0, 1) == 1) : 1'b1;
                    ld_chunk = c;
                    if (stress && $urandom_range(0, 5) == 0) begin
                        ld_start = 1'b1;
                        ld_addr = ADDR_W'($urandom());
                        ld_nwords = ADDR_W'($urandom());
                        ld_bad_par = 1'b1;
                    end else begin
                        ld_start = 1'b0;
                    end
                    acc_now = ld_valid & ld_ready;
                    cycle(stress, 1'b0);
                    guard++;
                end while (!acc_now && guard < 64);
                if (!acc_now) begin
                    check_val("slice_timeout", 128'(0), 128'(1));
                    aborted = 1'b1;
                    ld_start = 1'b0;
                    ld_valid = 1'b0;
                    return;
                end
            end
            ld_start = 1'b0;
            ld_valid = $urandom_range(0, 1) == 1;
            ld_chunk = CHUNK_W'($urandom());
            check_val("ready_low_in_write", 128'(ld_ready), 128'(0));
            cycle(1'b0, 1'b1);
            if (wa < DEPTH) begin
                model_mem[wa] = acc[BUF_W-1 -: WORD_W];
                model_bad[wa] = bad;
                if (!bad) good_q.push_back(wa);
            end
            wa = next_addr(wa);
            check_val("done_timing", 128'(ld_done), 128'(w == n));
        end
        ld_valid = 1'b0;
        check_val("busy_in_done", 128'(ld_busy), 128'(1));
        cycle(1'b0, 1'b0);
        check_val("done_one_cycle", 128'(ld_done), 128'(0));
        check_val("idle_after_done", 128'(ld_busy), 128'(0));
        check_val("par_clean", 128'(par_err), 128'(0));
    endtask

    initial begin
        int a;
        n_cmp = 0;
        n_err = 0;
        aborted = 1'b0;
        reset_n = 1'b0;
        cradr = '0;
        cram_hold = 1'b0;
        par_err_clr = 1'b0;
        ld_start = 1'b0;
        ld_addr = '0;
        ld_nwords = '0;
        ld_bad_par = 1'b0;
        ld_valid = 1'b0;
        ld_chunk = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cram_data", 128'(cram_data), 128'(0));
        check_val("rst_par_err", 128'(par_err), 128'(0));
        check_val("rst_ready", 128'(ld_ready), 128'(0));
        check_val("rst_busy", 128'(ld_busy), 128'(0));
        check_val("rst_done", 128'(ld_done), 128'(0));
        reset_n = 1'b1;

        // Unimplemented address reads zero with no parity error
        read_at(ASPACE - 1, "oor_read");
        read_at(DEPTH, "oor_read_edge");
        @(posedge clk);
        #1;
        check_val("oor_no_par", 128'(par_err), 128'(0));

        // Fixed two-word burst at 0x010
        fixed_slices = '{21'h1ABCD, 21'h02468, 21'h13579, 21'h0FFFF,
                         21'h10000, 21'h0AAAA, 21'h1F0F0, 21'h15555};
        load_burst(12'h010, 1, 1'b0, 1'b1);
        read_at(12'h010, "fixed_w0");
        check_val("fixed_w0_lit", 128'(cram_data),
                  128'({21'h1ABCD, 21'h02468, 21'h13579, 21'h0FFFF}));
        read_at(12'h011, "fixed_w1");
        check_val("fixed_w1_lit", 128'(cram_data),
                  128'({21'h10000, 21'h0AAAA, 21'h1F0F0, 21'h15555}));

        // Wrap from the last implemented word to 0
        load_burst(DEPTH - 1, 1, 1'b0, 1'b1);
        read_at(DEPTH - 1, "wrap_last");
        read_at(0, "wrap_zero");

        // Random bursts, including ones that start in unimplemented space
        for (int i = 0; i < 8 && !aborted; i++) begin
            case ($urandom_range(0, 3))
                0: a = int'($urandom_range(0, DEPTH - 1));
                1: a = DEPTH - 2;
                2: a = ASPACE - 1;
                default: a = int'($urandom_range(DEPTH, ASPACE - 1));
            endcase
            load_burst(a, int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end
        read_at(DEPTH + 1, "oor_after_drop");
        foreach (model_mem[k]) read_at(k, "readback");
        check_val("readback_par", 128'(par_err), 128'(0));

        // Bad parity word at 0x020
        load_burst(12'h020, 0, 1'b1, 1'b0);
        read_at(12'h020, "bad_word_data");
        check_val("par_not_yet", 128'(par_err), 128'(0));
        read_at(12'h010, "after_bad_read");
        check_val("par_set", 128'(par_err), 128'(1));
        read_at(12'h010, "sticky_read");
        check_val("par_sticky", 128'(par_err), 128'(1));
        par_err_clr = 1'b1;
        read_at(12'h010, "clr_read");
        par_err_clr = 1'b0;
        check_val("par_cleared", 128'(par_err), 128'(0));
        read_at(12'h020, "bad_again");
        par_err_clr = 1'b1;
        read_at(12'h010, "set_clr_read");
        par_err_clr = 1'b0;
        check_val("par_set_wins", 128'(par_err), 128'(1));
        par_err_clr = 1'b1;
        read_at(12'h010, "clr2_read");
        par_err_clr = 1'b0;
        check_val("par_cleared2", 128'(par_err), 128'(0));

        // Reset after two of four slices
        cradr = ADDR_W'(DEPTH);
        ld_addr = 12'h010;
        ld_nwords = '0;
        ld_bad_par = 1'b0;
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_chunk = CHUNK_W'($urandom());
        @(posedge clk);
        #1;
        ld_chunk = CHUNK_W'($urandom());
        @(posedge clk);
        #1;
        check_val("busy_mid_burst", 128'(ld_busy), 128'(1));
        reset_n = 1'b0;
        #1;
        check_val("rst_busy_async", 128'(ld_busy), 128'(0));
        check_val("rst_ready_async", 128'(ld_ready), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ld_valid = 1'b0;
        read_at(12'h010, "word_kept_after_rst");
        load_burst(12'h030, 2, 1'b0, 1'b1);
        read_at(12'h030, "post_rst_w0");
        read_at(12'h031, "post_rst_w1");
        read_at(12'h032, "post_rst_w2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
